sixty_four_bit_subtractor_seq: RTL
==================================

# sixty_four_bit_subtractor_seq

Multi-cycle 64-bit subtractor that computes DIFF = A − B, four bits per clock, with borrow propagated between cycles. It is the inverse operation to the team's 64-bit ripple-carry adder and sits beside it in the Lab 2 arithmetic datapath. A START/BUSY/DONE handshake lets a controller launch an operation and collect the result 17 cycles later. It also reports the unsigned borrow, signed overflow and zero flags.

## Interface
- No parameters. Width is fixed at 64 bits, 4 bits per cycle, 16 cycles.
- CLK  input  1  sole clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- A  input  64  minuend; captured on accepted START.
- B  input  64  subtrahend; captured on accepted START.
- DIFF  output  64  A − B modulo 2^64; valid while DONE=1 and held until next accepted START.
- BORROW  output  1  1 when A < B unsigned; valid with DIFF.
- OVERFLOW  output  1  signed overflow: A[63]≠B[63] and DIFF[63]≠A[63]; valid with DIFF.
- ZERO  output  1  DIFF == 0; valid with DIFF.
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse: result valid.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - START=1: capture A and B into internal operand registers, clear DIFF to 0, clear the borrow register, clear the nibble counter to 0, go to RUN.
  - START=0: stay in IDLE.
- RUN, one nibble per cycle, with i = counter (0..15):
  - {b, d} = {1'b0, Aop[4i+3:4i]} − {1'b0, Bop[4i+3:4i]} − borrow, computed as 5-bit arithmetic.
  - DIFF[4i+3:4i] ← d[3:0]; borrow ← b (bit 4 of the result); counter ← counter+1.
  - When i==15, go to FINISH.
- FINISH:
  - DONE=1 for exactly one cycle.
  - BORROW = final borrow; OVERFLOW and ZERO are computed from Aop, Bop and DIFF.
  - Next state is IDLE unconditionally.
- START is ignored in RUN and FINISH. It is not queued; the controller must hold or re-assert it in IDLE.
- Changes on A and B after the capture edge have no effect on the running operation.
- DIFF, BORROW, OVERFLOW and ZERO hold their values through IDLE until the next accepted START. At that point DIFF clears, and BORROW, OVERFLOW and ZERO clear to 0.
- Counter wraps 15→0 only on the transition to FINISH; counter is don't-care outside RUN.

## Timing
- Reset values, after any edge with RESET=1: state IDLE, DIFF=0, BORROW=0, OVERFLOW=0, ZERO=0, BUSY=0, DONE=0, counter=0, borrow register=0.
- RESET has priority over everything:
  - RESET and START high on the same edge: reset wins and START is dropped.
  - RESET during RUN or FINISH aborts the operation; no DONE pulse is produced.
- Latency, with START sampled high in IDLE at edge k:
  - BUSY=1 from after edge k through edge k+16.
  - Nibble i is written at edge k+1+i.
  - After edge k+16: state FINISH, BUSY=0, DONE=1.
  - After edge k+17: DONE=0, state IDLE.
  - Result is valid from the DONE cycle onward.
- Earliest back-to-back START is sampled at edge k+18, which gives throughput of one operation per 18 cycles.
- BUSY and DONE are never high simultaneously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: assert RESET for 2 cycles with START=1 → all outputs 0, BUSY never rises; release with START=0 → stays IDLE.
- Basic subtraction: A=0x0000_0000_0000_0010, B=0x1 → DONE 17 cycles after START, DIFF=0x0000_0000_0000_000F, BORROW=0, OVERFLOW=0, ZERO=0.
- Full borrow chain:
  - A=0, B=1 → DIFF=0xFFFF_FFFF_FFFF_FFFF, BORROW=1, OVERFLOW=0, ZERO=0.
  - A=B=0xDEAD_BEEF_0123_4567 → DIFF=0, ZERO=1, BORROW=0.
- Signed overflow:
  - A=0x8000_0000_0000_0000, B=1 → DIFF=0x7FFF_FFFF_FFFF_FFFF, OVERFLOW=1, BORROW=0.
  - A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF → DIFF=0x8000_0000_0000_0000, OVERFLOW=1, BORROW=1.
- Handshake robustness:
  - Pulse START again at cycles 5 and 16 of RUN with new A and B → ignored; result matches the first operands.
  - Hold START high continuously → operations start at edges k, k+18, k+36.
  - Change A and B mid-run → no effect on the running operation.
- Mid-operation reset and random check: assert RESET at RUN cycle 8 → no DONE, outputs 0; then run 1000 random A/B pairs → DIFF == (A−B) mod 2^64, and BORROW == (A<B) unsigned.

Source files
------------

// File: rtl/sixty_four_bit_subtractor_seq.sv
// Multi-cycle 64-bit subtractor: DIFF = A - B, one nibble per clock with the
// borrow carried between cycles, plus borrow/overflow/zero flags.
module sixty_four_bit_subtractor_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] diff,
  output logic        borrow,
  output logic        overflow,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] a_op;
  logic [63:0] b_op;
  logic [3:0]  cnt;
  logic        borrow_q;
  logic [5:0]  bit_idx;
  logic [4:0]  nib_sub;
  logic [63:0] diff_upd;

  // busy/done come from flops keyed on the next state so they align with state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == FINISH);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == 4'd15) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // 5-bit nibble subtract; bit 4 is the borrow out into the next nibble
  always_comb begin
    bit_idx  = {cnt, 2'b00};
    nib_sub  = {1'b0, a_op[bit_idx +: 4]} - {1'b0, b_op[bit_idx +: 4]} - {4'b0000, borrow_q};
    diff_upd = diff;
    diff_upd[bit_idx +: 4] = nib_sub[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_op     <= '0;
      b_op     <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      cnt      <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_op     <= a;
            b_op     <= b;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            cnt      <= '0;
            borrow_q <= 1'b0;
          end
        end
        RUN: begin
          diff     <= diff_upd;
          borrow_q <= nib_sub[4];
          cnt      <= cnt + 4'd1;
          // flags are taken from the completed result on the last nibble
          if (cnt == 4'd15) begin
            borrow   <= nib_sub[4];
            overflow <= (a_op[63] ^ b_op[63]) & (diff_upd[63] ^ a_op[63]);
            zero     <= (diff_upd == 64'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
